// File: rtl/mmio_host_pkg.sv
// Shared constants for the mmio_host simulation host: register map, STATUS layout
// and the halt-value encoding.
package mmio_host_pkg;

    typedef enum logic [2:0] {
        REG_HALT      = 3'd0,
        REG_SIG_BEGIN = 3'd1,
        REG_SIG_END   = 3'd2,
        REG_CONSOLE   = 3'd3,
        REG_CYCLE_LO  = 3'd4,
        REG_CYCLE_HI  = 3'd5,
        REG_TIMEOUT   = 3'd6,
        REG_STATUS    = 3'd7
    } reg_idx_e;

    localparam int unsigned ST_HALTED    = 0;
    localparam int unsigned ST_OVERFLOW  = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_FULL      = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    localparam logic [31:0] HALT_PASS = 32'd1;

    // A pass value reports code 0; any other value drops its LSB (the "done" bit).
    function automatic logic [31:0] halt_code_of(input logic is_pass, input logic [31:0] value);
        logic [31:0] code;
        if (is_pass) begin
            code = 32'd0;
        end else begin
            code = {1'b0, value[31:1]};
        end
        return code;
    endfunction

endpackage

// File: rtl/mmio_host_if.sv
// CPU data-port bus as seen by the mmio_host register window.
interface mmio_host_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] address;
    logic            store;
    logic            load;
    logic [XLEN-1:0] store_data;
    logic            hit;
    logic [XLEN-1:0] rdata;
    logic            rsel;

    modport master (
        output address, store, load, store_data,
        input  hit, rdata, rsel
    );

    modport slave (
        input  address, store, load, store_data,
        output hit, rdata, rsel
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head, flags and level; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [LW-1:0]    level_r, level_s;
    logic             empty_r, full_r, pop_ok_s, push_ok_s;
    logic [WIDTH-1:0] head_r, head_s;

    // Next pointers, level and head; a push landing on the new read slot bypasses memory.
    always_comb begin
        pop_ok_s  = pop & ~empty_r;
        push_ok_s = push & (~full_r | pop_ok_s);
        wr_ptr_s  = push_ok_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
        rd_ptr_s  = pop_ok_s  ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_s = level_r + LW'(1'b1);
            2'b01:   level_s = level_r - LW'(1'b1);
            default: level_s = level_r;
        endcase
        if (push_ok_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Storage and state registers; reset also clears the contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            head_r   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            level_r  <= level_s;
            empty_r  <= (level_s == LW'(0));
            full_r   <= (level_s == LW'(DEPTH));
            head_r   <= head_s;
        end
    end

    assign pop_data = head_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;

endmodule

// File: rtl/mmio_host.sv
// Memory-mapped simulation host: halt/signature registers, console FIFO,
// 64-bit cycle counter and watchdog behind an 8-word window at BASE.
module mmio_host
    import mmio_host_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] BASE       = XLEN'(32'h2000_0000),
    parameter int unsigned     FIFO_DEPTH = 16,
    parameter logic [31:0]     WDT_CODE   = 32'hDEAD
) (
    input  logic             clock,
    input  logic             reset,
    mmio_host_if.slave       bus,
    output logic             halted,
    output logic [31:0]      halt_code,
    output logic [XLEN-1:0]  sig_begin,
    output logic [XLEN-1:0]  sig_end,
    output logic             con_valid,
    output logic [7:0]       con_data,
    input  logic             con_ready
);
    localparam int unsigned     BYTES     = XLEN / 8;
    localparam int unsigned     IDX_LSB   = $clog2(BYTES);
    localparam int unsigned     LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(8 * BYTES);
    localparam logic [XLEN-1:0] ONE_X     = XLEN'(1'b1);

    logic [XLEN-1:0]  offset_s, rd_s;
    logic             in_win_s, wr_s, halt_wr_s, tmo_wr_s, wdt_expire_s;
    reg_idx_e         idx_s;
    logic [15:0]      status_s;

    logic             halted_r, halted_s, overflow_r, overflow_s, rsel_r;
    logic [31:0]      halt_code_r, halt_code_s;
    logic [XLEN-1:0]  sig_begin_r, sig_begin_s, sig_end_r, sig_end_s;
    logic [XLEN-1:0]  wdt_r, wdt_s, rdata_r;
    logic [63:0]      cycle_r, cycle_s;

    logic             fifo_push_s, fifo_full_s, fifo_empty_s;
    logic [7:0]       fifo_data_s;
    logic [LVL_W-1:0] fifo_level_s;

    // The lower bound check keeps addresses below BASE from wrapping into the window.
    assign offset_s     = bus.address - BASE;
    assign in_win_s     = (bus.address >= BASE) && (offset_s < WIN_BYTES);
    assign idx_s        = reg_idx_e'(offset_s[IDX_LSB +: 3]);
    assign bus.hit      = (bus.store | bus.load) & in_win_s;
    assign wr_s         = bus.store & in_win_s & ~halted_r;
    assign halt_wr_s    = wr_s && (idx_s == REG_HALT) && (bus.store_data != '0);
    assign tmo_wr_s     = wr_s && (idx_s == REG_TIMEOUT);
    assign wdt_expire_s = (wdt_r == ONE_X) && !tmo_wr_s;
    assign fifo_push_s  = wr_s && (idx_s == REG_CONSOLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (bus.store_data[7:0]),
        .pop       (con_ready),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // Read mux; CYCLE_HI shifts out to zero when XLEN already covers all 64 bits.
    always_comb begin
        status_s                    = 16'd0;
        status_s[ST_HALTED]         = halted_r;
        status_s[ST_OVERFLOW]       = overflow_r;
        status_s[ST_EMPTY]          = fifo_empty_s;
        status_s[ST_FULL]           = fifo_full_s;
        status_s[ST_LEVEL_LSB +: 8] = 8'(fifo_level_s);
        rd_s = '0;
        case (idx_s)
            REG_CYCLE_LO: rd_s = cycle_r[XLEN-1:0];
            REG_CYCLE_HI: rd_s = XLEN'(cycle_r >> XLEN);
            REG_TIMEOUT:  rd_s = wdt_r;
            REG_STATUS:   rd_s = XLEN'(status_s);
            default:      rd_s = '0;
        endcase
    end

    // Register writes, counter and watchdog; a halt store beats a same-cycle expiry.
    always_comb begin
        halted_s    = halted_r;
        halt_code_s = halt_code_r;
        sig_begin_s = sig_begin_r;
        sig_end_s   = sig_end_r;
        cycle_s     = cycle_r;
        wdt_s       = wdt_r;
        overflow_s  = overflow_r | (fifo_push_s & fifo_full_s & ~con_ready);
        if (halted_r) begin
            cycle_s = cycle_r;
        end else begin
            cycle_s = cycle_r + 64'd1;
            if (tmo_wr_s) begin
                wdt_s = bus.store_data;
            end else if (wdt_r != '0) begin
                wdt_s = wdt_r - ONE_X;
            end else begin
                wdt_s = wdt_r;
            end
            if (halt_wr_s) begin
                halted_s    = 1'b1;
                halt_code_s = halt_code_of(bus.store_data == XLEN'(HALT_PASS),
                                           bus.store_data[31:0]);
            end else if (wdt_expire_s) begin
                halted_s    = 1'b1;
                halt_code_s = WDT_CODE;
            end else begin
                halted_s    = 1'b0;
                halt_code_s = halt_code_r;
            end
            if (wr_s && (idx_s == REG_SIG_BEGIN)) begin
                sig_begin_s = XLEN'({1'b0, bus.store_data[31:1]});
            end else begin
                sig_begin_s = sig_begin_r;
            end
            if (wr_s && (idx_s == REG_SIG_END)) begin
                sig_end_s = XLEN'({1'b0, bus.store_data[31:1]}) - ONE_X;
            end else begin
                sig_end_s = sig_end_r;
            end
        end
    end

    // State and registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            halted_r    <= 1'b0;
            halt_code_r <= 32'd0;
            sig_begin_r <= '0;
            sig_end_r   <= '0;
            cycle_r     <= 64'd0;
            wdt_r       <= '0;
            overflow_r  <= 1'b0;
            rdata_r     <= '0;
            rsel_r      <= 1'b0;
        end else begin
            halted_r    <= halted_s;
            halt_code_r <= halt_code_s;
            sig_begin_r <= sig_begin_s;
            sig_end_r   <= sig_end_s;
            cycle_r     <= cycle_s;
            wdt_r       <= wdt_s;
            overflow_r  <= overflow_s;
            rdata_r     <= (bus.load && in_win_s) ? rd_s : '0;
            rsel_r      <= bus.load & in_win_s;
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.rsel  = rsel_r;
    assign halted    = halted_r;
    assign halt_code = halt_code_r;
    assign sig_begin = sig_begin_r;
    assign sig_end   = sig_end_r;
    assign con_valid = ~fifo_empty_s;
    assign con_data  = fifo_data_s;

endmodule

// File: tb/tb_mmio_host.sv
// Self-checking bench for mmio_host: scoreboard queues for load returns and console bytes.
module tb_mmio_host;

    localparam logic [31:0] BASE   = 32'h2000_0000;
    localparam logic [31:0] A_HALT = BASE;
    localparam logic [31:0] A_SIGB = BASE + 32'd4;
    localparam logic [31:0] A_SIGE = BASE + 32'd8;
    localparam logic [31:0] A_CON  = BASE + 32'd12;
    localparam logic [31:0] A_CLO  = BASE + 32'd16;
    localparam logic [31:0] A_CHI  = BASE + 32'd20;
    localparam logic [31:0] A_TMO  = BASE + 32'd24;
    localparam logic [31:0] A_STAT = BASE + 32'd28;

    logic        clock = 1'b0;
    logic        reset;
    logic        halted;
    logic [31:0] halt_code, sig_begin, sig_end;
    logic        con_valid, con_ready;
    logic [7:0]  con_data;

    always #5 clock = ~clock;

    mmio_host_if #(.XLEN(32)) bus ();

    mmio_host #(
        .XLEN       (32),
        .BASE       (BASE),
        .FIFO_DEPTH (16),
        .WDT_CODE   (32'hDEAD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .halted    (halted),
        .halt_code (halt_code),
        .sig_begin (sig_begin),
        .sig_end   (sig_end),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready)
    );

    typedef struct {
        logic        rsel;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] con_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         ticks   = 0;
    int         halt_ticks;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        ticks++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.store = 1'b0;
        bus.load  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        ticks = 0;
        rd_q.delete();
        con_q.delete();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.store_data = data;
        bus.store      = 1'b1;
        tick();
        bus.store = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr,
                           input logic exp_hit, input logic [31:0] exp_data);
        rd_exp_t e;
        bus.address = addr;
        bus.load    = 1'b1;
        #1;
        check_eq({tag, "_hit"}, 64'(bus.hit), 64'(exp_hit));
        e.rsel = exp_hit;
        e.data = exp_data;
        rd_q.push_back(e);
        @(posedge clock);
        ticks++;
        @(negedge clock);
        bus.load = 1'b0;
        e = rd_q.pop_front();
        check_eq({tag, "_rsel"}, 64'(bus.rsel), 64'(e.rsel));
        if (e.rsel) begin
            check_eq({tag, "_rdata"}, 64'(bus.rdata), 64'(e.data));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_halted"},    64'(halted),    64'd0);
        check_eq({tag, "_halt_code"}, 64'(halt_code), 64'd0);
        check_eq({tag, "_sig_begin"}, 64'(sig_begin), 64'd0);
        check_eq({tag, "_sig_end"},   64'(sig_end),   64'd0);
        check_eq({tag, "_con_valid"}, 64'(con_valid), 64'd0);
        check_eq({tag, "_con_data"},  64'(con_data),  64'd0);
        check_eq({tag, "_rdata"},     64'(bus.rdata), 64'd0);
        check_eq({tag, "_rsel"},      64'(bus.rsel),  64'd0);
    endtask

    // Console consumer: a byte transfers at the next rising edge when valid and ready.
    always @(negedge clock) begin
        #1;
        if (!reset && con_valid && con_ready) begin
            check_eq("con_expected", 64'(con_q.size() != 0), 64'd1);
            if (con_q.size() != 0) begin
                check_eq("con_data", 64'(con_data), 64'(con_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset          = 1'b1;
        con_ready      = 1'b0;
        bus.address    = 32'd0;
        bus.store      = 1'b0;
        bus.load       = 1'b0;
        bus.store_data = 32'd0;

        do_reset();
        check_reset_outputs("rst");

        repeat (100) tick();
        do_load("cyc100",   A_CLO,          1'b1, 32'(ticks));
        do_load("cyc_hi",   A_CHI,          1'b1, 32'd0);
        do_load("outside",  BASE + 32'd32,  1'b0, 32'd0);
        do_load("below",    BASE - 32'd4,   1'b0, 32'd0);
        do_load("wo_sigb",  A_SIGB,         1'b1, 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_store(A_CON, 32'h41 + 32'(i));
            if (i < 16) begin
                con_q.push_back(8'(32'h41 + 32'(i)));
            end
        end
        do_load("stat_ovf", A_STAT, 1'b1, 32'h0000_100A);
        check_eq("con_valid_full", 64'(con_valid), 64'd1);
        check_eq("con_head_full",  64'(con_data),  64'h41);
        con_ready = 1'b1;
        repeat (16) tick();
        check_eq("con_drained",     64'(con_q.size()), 64'd0);
        check_eq("con_valid_empty", 64'(con_valid),    64'd0);

        do_store(A_TMO, 32'd10);
        do_load("tmo_rd", A_TMO, 1'b1, 32'd10);
        repeat (8) tick();
        check_eq("wdt_early_halted", 64'(halted), 64'd0);
        tick();
        check_eq("wdt_halted",    64'(halted),    64'd1);
        check_eq("wdt_halt_code", 64'(halt_code), 64'hDEAD);
        halt_ticks = ticks;
        do_load("cyc_frz1", A_CLO, 1'b1, 32'(halt_ticks));
        repeat (5) tick();
        do_load("cyc_frz2", A_CLO, 1'b1, 32'(halt_ticks));
        do_store(A_TMO, 32'd3);
        do_load("tmo_frozen", A_TMO,  1'b1, 32'd0);
        do_load("stat_halt",  A_STAT, 1'b1, 32'h0000_0007);

        do_reset();
        do_store(A_SIGB, 32'h1000);
        do_store(A_SIGE, 32'h1100);
        do_store(A_TMO,  32'd2);
        tick();
        do_store(A_HALT, 32'h7);
        check_eq("fail_halted",    64'(halted),    64'd1);
        check_eq("fail_code",      64'(halt_code), 64'd3);
        check_eq("fail_sig_begin", 64'(sig_begin), 64'h800);
        check_eq("fail_sig_end",   64'(sig_end),   64'h87F);
        do_store(A_HALT, 32'd5);
        check_eq("fail_code_kept", 64'(halt_code), 64'd3);
        do_load("wo_sige", A_SIGE, 1'b1, 32'd0);

        do_reset();
        do_store(A_HALT, 32'd1);
        check_eq("pass_halted", 64'(halted),    64'd1);
        check_eq("pass_code",   64'(halt_code), 64'd0);
        do_store(A_HALT, 32'd5);
        check_eq("pass_code_kept", 64'(halt_code), 64'd0);

        do_reset();
        con_ready = 1'b0;
        do_store(A_SIGB, 32'h40);
        do_store(A_SIGE, 32'h100);
        for (int i = 0; i < 3; i++) begin
            do_store(A_CON, 32'h61 + 32'(i));
        end
        do_store(A_TMO, 32'd50);
        check_eq("mid_con_valid", 64'(con_valid), 64'd1);
        check_eq("mid_con_data",  64'(con_data),  64'h61);
        do_load("mid_stat", A_STAT, 1'b1, 32'h0000_0300);
        reset       = 1'b1;
        bus.address = A_STAT;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        check_reset_outputs("midrst");
        reset = 1'b0;
        ticks = 0;
        do_load("tmo_after_rst",  A_TMO,  1'b1, 32'd0);
        do_load("stat_after_rst", A_STAT, 1'b1, 32'h0000_0004);
        do_load("cyc_after_rst",  A_CLO,  1'b1, 32'(ticks));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
